// File: rtl/ble4_cfg_pkg.sv
// Shared types and constants for the ble4 configuration loader.
package ble4_cfg_pkg;

  localparam int BLE4_CNT_W = 5;

  localparam logic BLE4_BANK_LUT = 1'b0;
  localparam logic BLE4_BANK_MUX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } ble4_state_e;

endpackage

// File: rtl/ble4_cfg_addr_map.sv
// Maps a serial bit index onto the ble4 decoder address: LUT bank first, then
// the output-mux bank with the mux index in the two leading address bits.
module ble4_cfg_addr_map
  import ble4_cfg_pkg::*;
#(
  parameter int NUM_LUT_BITS = 16
) (
  input  logic [BLE4_CNT_W-1:0] index,
  output logic [0:4]            address
);

  localparam logic [BLE4_CNT_W-1:0] LUT_N = BLE4_CNT_W'(NUM_LUT_BITS);

  // Only the low two bits of the mux-bank offset reach the address.
  logic [1:0] mux_lo;

  always_comb begin
    mux_lo  = index[1:0] - LUT_N[1:0];
    address = '0;
    if (index < LUT_N) begin
      address[0:3] = index[3:0];
      address[4]   = BLE4_BANK_LUT;
    end else begin
      address[0:1] = mux_lo;
      address[2:3] = 2'b00;
      address[4]   = BLE4_BANK_MUX;
    end
  end

endmodule

// File: rtl/ble4_cfg_loader.sv
// Serial configuration loader for a ble4 block: one decoder write per accepted bit.
// Optional even-parity check of the loaded stream enabled by BLE4_CFG_PARITY_EN.
module ble4_cfg_loader
  import ble4_cfg_pkg::*;
#(
  parameter int NUM_LUT_BITS = 16,
  parameter int NUM_MUX_BITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cfg_valid,
  input  logic        cfg_bit,
  output logic        cfg_ready,
  output logic [0:0]  enable,
  output logic [0:4]  address,
  output logic [0:0]  data_in,
  output logic        busy,
  output logic        done,
`ifdef BLE4_CFG_PARITY_EN
  output logic        cfg_error,
`endif
  output ble4_state_e fsm_state
);

  localparam logic [BLE4_CNT_W-1:0] LAST_IDX =
    BLE4_CNT_W'(NUM_LUT_BITS + NUM_MUX_BITS - 1);

  ble4_state_e           state, state_next;
  logic [BLE4_CNT_W-1:0] count;
  logic [0:4]            map_addr;
  logic                  start_ok;
  logic                  load_accept;

  assign fsm_state = state;

  ble4_cfg_addr_map #(
    .NUM_LUT_BITS(NUM_LUT_BITS)
  ) u_addr_map (
    .index  (count),
    .address(map_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_LOAD;
      ST_LOAD:  if (load_accept && count == LAST_IDX) state_next = ST_CHECK;
`ifdef BLE4_CFG_PARITY_EN
      ST_CHECK: if (cfg_valid) state_next = ST_DONE;
`else
      ST_CHECK: state_next = ST_DONE;
`endif
      ST_DONE:  state_next = start_ok ? ST_LOAD : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake: a bit transfers on a rising edge where cfg_valid and cfg_ready
  // are both 1; cfg_ready depends on state only, never on cfg_valid.
  always_comb begin
    busy = (state == ST_LOAD) || (state == ST_CHECK);
`ifdef BLE4_CFG_PARITY_EN
    cfg_ready = busy;
`else
    cfg_ready = (state == ST_LOAD);
`endif
    start_ok    = start && !busy;
    load_accept = cfg_valid && cfg_ready && (state == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= '0;
      address <= '0;
      data_in <= '0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      enable <= load_accept;
      if (load_accept) begin
        address <= map_addr;
        data_in <= cfg_bit;
        count   <= count + 1'b1;
      end
      if (start_ok) begin
        count <= '0;
        done  <= 1'b0;
      end else if (state == ST_CHECK && state_next == ST_DONE) begin
        done <= 1'b1;
      end
    end
  end

`ifdef BLE4_CFG_PARITY_EN
  logic parity;

  // parity tracks the XOR of the loaded bits; the trailing bit must even it out.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity    <= 1'b0;
      cfg_error <= 1'b0;
    end else if (start_ok) begin
      parity    <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      if (load_accept) parity <= parity ^ cfg_bit;
      if (state == ST_CHECK && cfg_valid && (parity ^ cfg_bit)) cfg_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ble4_cfg_loader.sv
// Directed bench for ble4_cfg_loader; build with BLE4_CFG_PARITY_EN to cover parity.
module tb_ble4_cfg_loader;
  import ble4_cfg_pkg::*;

  localparam int NBITS = 19;

  logic        clk = 1'b0;
  logic        reset, start, cfg_valid, cfg_bit;
  logic        cfg_ready, busy, done;
  logic [0:0]  enable, data_in;
  logic [0:4]  address;
  ble4_state_e fsm_state;
`ifdef BLE4_CFG_PARITY_EN
  logic        cfg_error;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;
  logic [5:0] exp_q[$];

  ble4_cfg_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_ready(cfg_ready),
    .enable   (enable),
    .address  (address),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
`ifdef BLE4_CFG_PARITY_EN
    .cfg_error(cfg_error),
`endif
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {address[0:4], data_in} for bit k.
  function automatic logic [5:0] exp_write(input int k, input logic b);
    logic [4:0] kk;
    logic [4:0] j;
    kk = k[4:0];
    j  = kk - 5'd16;
    if (k < 16) return {kk[3:0], 1'b0, b};
    else        return {j[1:0], 2'b00, 1'b1, b};
  endfunction

  // scoreboard: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else check("strobe", {26'd0, address, data_in}, {26'd0, exp_q.pop_front()});
    end
  end

  // drivers: all tasks begin and end just after a falling edge
  task automatic put_bit(input int k, input logic b);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    exp_q.push_back(exp_write(k, b));
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    cfg_valid = 1'b0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, exp_lat);
  endtask

  task automatic run_seq(input logic [NBITS-1:0] bits, input int gap_at,
                         input int start_at, input logic pbit, input logic exp_err);
    int s0;
    s0 = strobes;
    do_start();
    check("start_done_clear", done, 1'b0);
    check("start_busy", busy, 1'b1);
    check("start_ready", cfg_ready, 1'b1);
    for (int k = 0; k < NBITS; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          cfg_valid = 1'b0;
          @(negedge clk);
          check("gap_enable", enable, 1'b0);
        end
      end
      if (k == start_at) start = 1'b1;
      put_bit(k, bits[k]);
      start = 1'b0;
    end
`ifdef BLE4_CFG_PARITY_EN
    cfg_valid = 1'b1;
    cfg_bit   = pbit;
    @(negedge clk);
    wait_done(0);
    check("cfg_error", cfg_error, exp_err);
`else
    check("pbit_unused", {pbit, exp_err}, {pbit, exp_err});
    wait_done(1);
`endif
    check("done_busy", busy, 1'b0);
    check("strobe_total", strobes - s0, NBITS);
  endtask

  logic [NBITS-1:0] alt_bits, seven_bits;

  initial begin
    reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    for (int k = 0; k < NBITS; k++) alt_bits[k] = (k % 2 == 0);
    seven_bits = 19'b000_1000_0101_0011_0101;

    repeat (3) @(negedge clk);
    check("rst_enable", enable, 1'b0);
    check("rst_address", {27'd0, address}, 32'd0);
    check("rst_data", data_in, 1'b0);
    check("rst_ready", cfg_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
`ifdef BLE4_CFG_PARITY_EN
    check("rst_cfg_error", cfg_error, 1'b0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", fsm_state, ST_IDLE);

    // contiguous alternating bits
    run_seq(alt_bits, -1, -1, ^alt_bits, 1'b0);
    @(negedge clk);
    check("done_level", done, 1'b1);
    check("idle_after_done", fsm_state, ST_IDLE);

    // three-cycle valid gap before bit 6
    run_seq(alt_bits, 6, -1, ^alt_bits, 1'b0);

    // reset after bit 10: strobe dropped, no writes until a new start
    do_start();
    for (int k = 0; k <= 10; k++) put_bit(k, alt_bits[k]);
    cfg_valid = 1'b1; cfg_bit = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("midrst_enable", enable, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", cfg_ready, 1'b0);
    check("midrst_address", {27'd0, address}, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_enable", enable, 1'b0);
    end
    cfg_valid = 1'b0;
    check("post_rst_done", done, 1'b0);
    check("post_rst_queue", exp_q.size(), 0);

    // start pulsed alongside bit 8 is ignored
    run_seq(alt_bits, -1, 8, ^alt_bits, 1'b0);

    // back-to-back: restart straight out of DONE
    check("done_before_restart", done, 1'b1);
    run_seq(seven_bits, -1, -1, ^seven_bits, 1'b0);

`ifdef BLE4_CFG_PARITY_EN
    check("seven_ones", $countones(seven_bits), 7);
    run_seq(seven_bits, -1, -1, 1'b0, 1'b1);
    @(negedge clk);
    check("error_sticky", cfg_error, 1'b1);
    run_seq(seven_bits, -1, -1, 1'b1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
